// File: rtl/spi_cmd_decoder.sv
// SPI command decoder: resynchronises the SPI receiver handshake, decodes read/write
// frames into a four-entry register file and drives a fan PWM from duty/prescale.
module spi_cmd_decoder #(
    parameter logic [7:0] ID_VALUE    = 8'hA5,
    parameter int         SYNC_STAGES = 2
) (
    input  logic        sysclk,
    input  logic        iReset,
    input  logic        iRxReady,
    input  logic [7:0]  iRx,
    input  logic        iSPICS,
    output logic        oTxReady,
    output logic [7:0]  oTx,
    output logic        oPwm,
    output logic [15:0] oProbe
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CMD   = 2'd1,
        WDATA = 2'd2,
        HOLD  = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] rx_sync_r;
    logic [SYNC_STAGES-1:0] cs_sync_r;
    logic                   rx_sync_s;
    logic                   cs_sync_s;
    logic                   rx_prev_r;
    logic                   cs_prev_r;
    logic                   rx_edge_r;
    logic [7:0]             byte_r;
    logic [7:0]             frame_count_r;

    state_t                 state_r;
    state_t                 state_nxt_s;
    logic [1:0]             addr_r;
    logic [1:0]             addr_nxt_s;
    logic [7:0]             tx_r;
    logic [7:0]             tx_nxt_s;
    logic                   tx_ready_r;
    logic                   tx_ready_nxt_s;
    logic                   wr_en_s;
    logic [7:0]             rd_data_s;

    logic [7:0]             duty_r;
    logic [7:0]             prescale_r;
    logic [7:0]             scratch_r;
    logic [7:0]             active_duty_r;
    logic [7:0]             pwm_cnt_r;
    logic [7:0]             presc_cnt_r;
    logic                   pwm_r;

    assign rx_sync_s = rx_sync_r[SYNC_STAGES-1];
    assign cs_sync_s = cs_sync_r[SYNC_STAGES-1];

    // Input synchronisers; CS idles high so a reset never looks like a frame start.
    always_ff @(posedge sysclk) begin
        if (iReset) begin
            rx_sync_r <= {SYNC_STAGES{1'b0}};
            cs_sync_r <= {SYNC_STAGES{1'b1}};
            rx_prev_r <= 1'b0;
            cs_prev_r <= 1'b1;
        end else begin
            rx_sync_r <= {rx_sync_r[SYNC_STAGES-2:0], iRxReady};
            cs_sync_r <= {cs_sync_r[SYNC_STAGES-2:0], iSPICS};
            rx_prev_r <= rx_sync_s;
            cs_prev_r <= cs_sync_s;
        end
    end

    // Byte-valid edge detect, byte capture and frame counter.
    always_ff @(posedge sysclk) begin
        if (iReset) begin
            rx_edge_r     <= 1'b0;
            byte_r        <= 8'h00;
            frame_count_r <= 8'h00;
        end else begin
            rx_edge_r <= rx_sync_s & ~rx_prev_r;
            if (rx_sync_s && !rx_prev_r) begin
                byte_r <= iRx;
            end
            if (cs_prev_r && !cs_sync_s) begin
                frame_count_r <= frame_count_r + 8'd1;
            end
        end
    end

    // Register read mux addressed by the command byte.
    always_comb begin
        rd_data_s = ID_VALUE;
        case (byte_r[1:0])
            2'd0:    rd_data_s = duty_r;
            2'd1:    rd_data_s = prescale_r;
            2'd2:    rd_data_s = scratch_r;
            default: rd_data_s = ID_VALUE;
        endcase
    end

    // Frame decoder next-state logic; a deasserted CS overrides any byte in flight.
    always_comb begin
        state_nxt_s    = state_r;
        addr_nxt_s     = addr_r;
        tx_nxt_s       = tx_r;
        tx_ready_nxt_s = tx_ready_r;
        wr_en_s        = 1'b0;
        if (cs_sync_s) begin
            state_nxt_s    = IDLE;
            tx_nxt_s       = 8'h00;
            tx_ready_nxt_s = 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    state_nxt_s = CMD;
                end
                CMD: begin
                    if (rx_edge_r) begin
                        if (byte_r[7]) begin
                            addr_nxt_s  = byte_r[1:0];
                            state_nxt_s = WDATA;
                        end else begin
                            tx_nxt_s       = rd_data_s;
                            tx_ready_nxt_s = 1'b1;
                            state_nxt_s    = HOLD;
                        end
                    end else begin
                        state_nxt_s = CMD;
                    end
                end
                WDATA: begin
                    if (rx_edge_r) begin
                        wr_en_s     = 1'b1;
                        state_nxt_s = HOLD;
                    end else begin
                        state_nxt_s = WDATA;
                    end
                end
                HOLD: begin
                    state_nxt_s = HOLD;
                end
                default: begin
                    state_nxt_s    = IDLE;
                    tx_nxt_s       = 8'h00;
                    tx_ready_nxt_s = 1'b0;
                end
            endcase
        end
    end

    // Frame decoder state and response registers.
    always_ff @(posedge sysclk) begin
        if (iReset) begin
            state_r    <= IDLE;
            addr_r     <= 2'd0;
            tx_r       <= 8'h00;
            tx_ready_r <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            addr_r     <= addr_nxt_s;
            tx_r       <= tx_nxt_s;
            tx_ready_r <= tx_ready_nxt_s;
        end
    end

    // Writable registers; address 3 is the read-only ID so writes there are dropped.
    always_ff @(posedge sysclk) begin
        if (iReset) begin
            duty_r     <= 8'h00;
            prescale_r <= 8'h00;
            scratch_r  <= 8'h00;
        end else if (wr_en_s) begin
            case (addr_r)
                2'd0:    duty_r     <= byte_r;
                2'd1:    prescale_r <= byte_r;
                2'd2:    scratch_r  <= byte_r;
                default: ;
            endcase
        end
    end

    // PWM timebase; duty is only adopted at period wrap so a pulse is never cut short.
    always_ff @(posedge sysclk) begin
        if (iReset) begin
            presc_cnt_r   <= 8'h00;
            pwm_cnt_r     <= 8'h00;
            active_duty_r <= 8'h00;
            pwm_r         <= 1'b0;
        end else begin
            pwm_r <= (pwm_cnt_r < active_duty_r);
            if (presc_cnt_r > prescale_r) begin
                presc_cnt_r <= 8'h00;
            end else if (presc_cnt_r == prescale_r) begin
                presc_cnt_r <= 8'h00;
                pwm_cnt_r   <= pwm_cnt_r + 8'd1;
                if (pwm_cnt_r == 8'hFF) begin
                    active_duty_r <= duty_r;
                end
            end else begin
                presc_cnt_r <= presc_cnt_r + 8'd1;
            end
        end
    end

    assign oTxReady = tx_ready_r;
    assign oTx      = tx_r;
    assign oPwm     = pwm_r;
    assign oProbe   = {frame_count_r, 2'b00, state_r, 1'b0, rx_edge_r, cs_sync_s, tx_ready_r};

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// Directed bench for spi_cmd_decoder: table of register transactions plus
// hand-written sequences for latency, CS abort, reset abort and PWM behaviour.
module tb_spi_cmd_decoder;

    logic        sysclk;
    logic        iReset;
    logic        iRxReady;
    logic [7:0]  iRx;
    logic        iSPICS;
    logic        oTxReady;
    logic [7:0]  oTx;
    logic        oPwm;
    logic [15:0] oProbe;

    int checks;
    int failures;
    int fc;
    int rx_at;
    int tx_at;
    int hi;
    int pulse;
    bit ok;

    typedef struct {
        bit         is_write;
        logic [7:0] cmd;
        logic [7:0] data;
        logic [7:0] exp_tx;
    } vec_t;

    vec_t vecs [9];

    spi_cmd_decoder #(.ID_VALUE(8'hA5), .SYNC_STAGES(2)) dut (
        .sysclk   (sysclk),
        .iReset   (iReset),
        .iRxReady (iRxReady),
        .iRx      (iRx),
        .iSPICS   (iSPICS),
        .oTxReady (oTxReady),
        .oTx      (oTx),
        .oPwm     (oPwm),
        .oProbe   (oProbe)
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    task automatic tick(input int n);
        repeat (n) @(negedge sysclk);
    endtask

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic cs_low();
        iSPICS = 1'b0;
        fc++;
        tick(4);
    endtask

    task automatic cs_high();
        iSPICS = 1'b1;
        tick(4);
    endtask

    task automatic send_byte(input logic [7:0] b);
        iRx      = b;
        iRxReady = 1'b1;
        tick(4);
        iRxReady = 1'b0;
        tick(3);
    endtask

    task automatic do_write(input logic [7:0] cmd, input logic [7:0] d);
        cs_low();
        send_byte(cmd);
        send_byte(d);
        cs_high();
    endtask

    task automatic wait_rise(output bit found);
        logic p;
        found = 1'b0;
        p = oPwm;
        for (int c = 0; c < 2000; c++) begin
            tick(1);
            if (!p && oPwm) begin
                found = 1'b1;
                break;
            end
            p = oPwm;
        end
    endtask

    task automatic measure_pulse(output int n);
        n = 1;
        for (int c = 0; c < 600; c++) begin
            tick(1);
            if (oPwm) n++;
            else break;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        checks   = 0;
        failures = 0;
        fc       = 0;
        vecs[0] = '{1'b1, 8'h80, 8'h40, 8'h00};
        vecs[1] = '{1'b0, 8'h00, 8'h00, 8'h40};
        vecs[2] = '{1'b1, 8'h83, 8'h12, 8'h00};
        vecs[3] = '{1'b0, 8'h03, 8'h00, 8'hA5};
        vecs[4] = '{1'b1, 8'h82, 8'h5A, 8'h00};
        vecs[5] = '{1'b0, 8'h02, 8'h00, 8'h5A};
        vecs[6] = '{1'b1, 8'h81, 8'h00, 8'h00};
        vecs[7] = '{1'b0, 8'h7D, 8'h00, 8'h00};
        vecs[8] = '{1'b0, 8'h7C, 8'h00, 8'h40};

        iReset   = 1'b1;
        iRxReady = 1'b0;
        iRx      = 8'h00;
        iSPICS   = 1'b1;
        tick(3);
        iReset = 1'b0;
        chk("reset_probe", oProbe, 16'h0002);
        chk("reset_tx", 16'(oTx), 16'h0000);
        chk("reset_txready", 16'(oTxReady), 16'h0000);
        chk("reset_pwm", 16'(oPwm), 16'h0000);
        tick(2);

        // Register transaction table
        for (int i = 0; i < 9; i++) begin
            cs_low();
            send_byte(vecs[i].cmd);
            if (vecs[i].is_write) begin
                chk($sformatf("v%0d_state_wdata", i), 16'(oProbe[5:4]), 16'd2);
                send_byte(vecs[i].data);
                chk($sformatf("v%0d_state_hold", i), 16'(oProbe[5:4]), 16'd3);
                send_byte(8'h00);
                chk($sformatf("v%0d_wr_txready", i), 16'(oTxReady), 16'd0);
                chk($sformatf("v%0d_wr_tx", i), 16'(oTx), 16'd0);
            end else begin
                chk($sformatf("v%0d_rd_tx", i), 16'(oTx), 16'(vecs[i].exp_tx));
                chk($sformatf("v%0d_rd_txready", i), 16'(oTxReady), 16'd1);
                send_byte(vecs[i].cmd ^ 8'h01);
                chk($sformatf("v%0d_hold_tx", i), 16'(oTx), 16'(vecs[i].exp_tx));
            end
            cs_high();
            chk($sformatf("v%0d_end_tx", i), 16'(oTx), 16'd0);
            chk($sformatf("v%0d_end_txready", i), 16'(oTxReady), 16'd0);
            chk($sformatf("v%0d_end_state", i), 16'(oProbe[5:4]), 16'd0);
            chk($sformatf("v%0d_framecount", i), 16'(oProbe[15:8]), 16'(fc[7:0]));
        end

        // Read latency and CS-release clearing
        cs_low();
        rx_at = 0;
        tx_at = 0;
        iRx      = 8'h03;
        iRxReady = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            tick(1);
            if (oProbe[2] && rx_at == 0) rx_at = c;
            if (oTxReady && tx_at == 0) tx_at = c;
        end
        chk("lat_rxedge", 16'(rx_at), 16'd3);
        chk("lat_txready", 16'(tx_at), 16'd4);
        chk("lat_tx_id", 16'(oTx), 16'h00A5);
        iRxReady = 1'b0;
        tick(3);
        iSPICS = 1'b1;
        tick(3);
        chk("csrel_txready", 16'(oTxReady), 16'd0);
        chk("csrel_tx", 16'(oTx), 16'd0);
        tick(2);

        // CS release coinciding with the write-data byte edge
        cs_low();
        send_byte(8'h82);
        chk("abort_state_wdata", 16'(oProbe[5:4]), 16'd2);
        iRx      = 8'h77;
        iRxReady = 1'b1;
        tick(1);
        iSPICS = 1'b1;
        tick(2);
        chk("abort_coincide", 16'(oProbe[2:1]), 16'd3);
        tick(1);
        chk("abort_state_idle", 16'(oProbe[5:4]), 16'd0);
        iRxReady = 1'b0;
        tick(4);
        cs_low();
        send_byte(8'h02);
        chk("abort_scratch", 16'(oTx), 16'h005A);
        cs_high();

        // PWM at prescale 0, duty 0x80, then a mid-period duty change
        do_write(8'h80, 8'h80);
        tick(600);
        hi = 0;
        for (int c = 0; c < 256; c++) begin
            tick(1);
            if (oPwm) hi++;
        end
        chk("pwm_duty80_count", 16'(hi), 16'd128);
        wait_rise(ok);
        chk("pwm_rise1_found", 16'(ok), 16'd1);
        fork
            do_write(8'h80, 8'h10);
            measure_pulse(pulse);
        join
        chk("pwm_old_duty_pulse", 16'(pulse), 16'd128);
        wait_rise(ok);
        chk("pwm_rise2_found", 16'(ok), 16'd1);
        measure_pulse(pulse);
        chk("pwm_new_duty_pulse", 16'(pulse), 16'd16);

        // Prescale 1 doubles each PWM step
        do_write(8'h81, 8'h01);
        do_write(8'h80, 8'h40);
        tick(1100);
        wait_rise(ok);
        chk("pwm_presc_rise_found", 16'(ok), 16'd1);
        measure_pulse(pulse);
        chk("pwm_presc1_pulse", 16'(pulse), 16'd128);

        // Reset in WDATA aborts the frame and clears everything
        cs_low();
        send_byte(8'h80);
        chk("rst_state_wdata", 16'(oProbe[5:4]), 16'd2);
        iReset = 1'b1;
        tick(1);
        iReset = 1'b0;
        chk("rst_probe", oProbe, 16'h0002);
        chk("rst_tx", 16'(oTx), 16'd0);
        chk("rst_txready", 16'(oTxReady), 16'd0);
        chk("rst_pwm", 16'(oPwm), 16'd0);
        fc = 1;
        tick(4);
        send_byte(8'h44);
        cs_high();
        cs_low();
        send_byte(8'h00);
        chk("rst_duty_cleared", 16'(oTx), 16'd0);
        cs_high();
        cs_low();
        send_byte(8'h01);
        chk("rst_prescale_cleared", 16'(oTx), 16'd0);
        cs_high();
        chk("rst_framecount", 16'(oProbe[15:8]), 16'(fc[7:0]));
        tick(300);
        chk("rst_pwm_idle", 16'(oPwm), 16'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spi_cmd_decoder.md
SPI_CMD_DECODER -- requirements
Module: spi_cmd_decoder

Interface
REQ-001 SHALL have one clock; reset is synchronous and active-high.
REQ-002 SHALL have parameter ID_VALUE, default 8'hA5, read-only identification value at address 3.
REQ-003 SHALL have parameter SYNC_STAGES, default 2, flop count of each input synchronizer (min 2).
REQ-004 SHALL have port sysclk  in  1  system clock; all logic on rising edge.
REQ-005 SHALL have port iReset  in  1  synchronous active-high reset.
REQ-006 SHALL have port iRxReady  in  1  byte-valid level from SPI receiver (SPI clock domain).
REQ-007 SHALL have port iRx  in  8  received byte, stable while iRxReady high.
REQ-008 SHALL have port iSPICS  in  1  raw chip select, active-low, high = no frame.
REQ-009 SHALL have port oTxReady  out  1  response byte valid to SPI transmitter.
REQ-010 SHALL have port oTx  out  8  response byte.
REQ-011 SHALL have port oPwm  out  1  fan PWM output.
REQ-012 SHALL have port oProbe  out  16  debug: {frameCount[7:0], 2'b0, state[1:0], 1'b0, rxEdge, csSync, oTxReady}.

Function
REQ-013 SHALL pass iRxReady and iSPICS each through SYNC_STAGES flops; all logic uses synced versions only.
REQ-014 SHALL generate rxEdge, one cycle high, on synced iRxReady 0->1; iRx captured into byteReg that cycle.
REQ-015 SHALL implement FSM states IDLE, CMD, WDATA, HOLD.
REQ-016 IDLE: synced CS low -> CMD; else stay.
REQ-017 CMD, rxEdge, byte bit7=1 (write): latch address byte[1:0], go WDATA.
REQ-018 CMD, rxEdge, bit7=0 (read): oTx <= register[byte[1:0]], oTxReady <= 1 next cycle, go HOLD.
REQ-019 WDATA, rxEdge: write byte to latched address, go HOLD; write to address 3 discarded.
REQ-020 HOLD: further bytes ignored, no register writes, oTx/oTxReady unchanged.
REQ-021 Any state, synced CS high: next state IDLE, oTxReady <= 0, oTx <= 0; CS-high wins over rxEdge same cycle (byte discarded, no write).
REQ-022 Registers: addr0 duty[7:0], addr1 prescale[7:0], addr2 scratch[7:0], addr3 ID_VALUE (read-only).
REQ-023 frameCount SHALL increment (mod 256, wraps 255->0) on every synced CS 1->0.
REQ-024 Latency: iRxReady pin rise -> rxEdge = SYNC_STAGES+1 cycles; rxEdge -> oTxReady high = 1 cycle.
REQ-025 PWM: prescale counter counts 0..prescale, then pwmCnt[7:0] increments (wraps 255->0).
REQ-026 oPwm SHALL be registered, high when pwmCnt < activeDuty; duty 0 = always low, 255 = high 255/256 of period.
REQ-027 activeDuty SHALL load from duty register only when pwmCnt wraps 255->0 (glitch-free update).
REQ-028 Prescale change SHALL take effect at next prescale-counter terminal count; if counter > new prescale, counter resets to 0 next cycle.

Reset
REQ-029 On iReset: state IDLE, oTxReady 0, oTx 0, oPwm 0, duty 0, prescale 0, scratch 0, activeDuty 0, pwmCnt 0, prescale counter 0, frameCount 0, sync flops 1 for CS and 0 for RxReady.
REQ-030 Reset mid-frame SHALL abort; FSM re-enters CMD only after next synced CS 1->0.

Verification
REQ-031 CS low, bytes 0x80,0x40, CS high -> duty=0x40; oTxReady stays 0; frameCount=1.
REQ-032 CS low, byte 0x03 -> oTx=0xA5, oTxReady=1 at rxEdge+1; CS high -> both 0 within SYNC_STAGES+1 cycles.
REQ-033 Write 0x83,0x12 then read 0x03 -> oTx=0xA5 (write ignored); write 0x82,0x5A then read 0x02 -> oTx=0x5A.
REQ-034 prescale=0, duty=0x80 -> oPwm high 128 of 256 cycles; duty change to 0x10 mid-period -> old duty until pwmCnt wraps.
REQ-035 CS high same cycle as rxEdge of write data -> register unchanged, FSM IDLE.
REQ-036 iReset asserted during WDATA -> all REQ-029 values next cycle; subsequent data byte without new CS fall causes no write.
